// File: rtl/mp_deserializer.sv
// rtl/mp_deserializer.sv - gathers width_p-bit serial words into els_p-word frames.
// Alignment is taken from first_i; completed frames are held for a valid/yumi consumer.
module mp_deserializer #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic                       first_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       v_o,
  output logic [width_p*els_p-1:0]   data_o,
  input  logic                       yumi_i,
  output logic                       overflow_o,
  output logic                       frame_err_o
);

  localparam int cnt_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w-1:0] last_slot = cnt_w'(els_p - 1);

  localparam logic state_hunt = 1'b0;
  localparam logic state_fill = 1'b1;

  logic                       state;
  logic [cnt_w-1:0]           cnt;
  logic [width_p*els_p-1:0]   fill;

  logic                       hunt_start;
  logic                       realign;
  logic                       accept;
  logic [cnt_w-1:0]           wslot;
  logic [width_p*els_p-1:0]   base;
  logic [width_p*els_p-1:0]   assembled;
  logic                       complete;
  logic [cnt_w-1:0]           cnt_next;

  always_comb begin
    hunt_start = (state == state_hunt) && v_i && first_i;
    realign    = (state == state_fill) && v_i && first_i && (cnt != '0);
    accept     = hunt_start || ((state == state_fill) && v_i);
    wslot      = (hunt_start || realign) ? '0 : cnt;
    // A misplaced first_i throws away the partial frame before restarting at slot 0.
    base       = realign ? '0 : fill;
    assembled  = base;
    for (int k = 0; k < els_p; k++) begin
      if (accept && (wslot == cnt_w'(k))) begin
        assembled[k*width_p +: width_p] = data_i;
      end
    end
    complete   = accept && (wslot == last_slot);
    cnt_next   = complete ? '0 : wslot + cnt_w'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= state_hunt;
      cnt         <= '0;
      fill        <= '0;
      v_o         <= 1'b0;
      data_o      <= '0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (accept) begin
        state <= state_fill;
        cnt   <= cnt_next;
        fill  <= assembled;
      end
      if (realign) begin
        frame_err_o <= 1'b1;
      end
      // A new frame may replace the held one only if the consumer takes it on this edge.
      if (complete) begin
        if (!v_o || yumi_i) begin
          data_o <= assembled;
          v_o    <= 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
      end else if (yumi_i && v_o) begin
        v_o <= 1'b0;
      end
    end
  end

endmodule
